// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph, ASCII and state definitions for the seven-segment display path.
// Glyphs are active-low with bit0=a through bit6=g.
package seg_pkg;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] HEX_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] SPACE = 8'h20;
    typedef enum logic {IDLE, ACTIVE} state_e;
    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_CLEAR} op_e;
endpackage

// File: rtl/ascii_glyph_decoder.sv
// ascii_glyph_decoder: classifies a received byte into a window operation and its glyph.
// Ports: byte_i (received byte), glyph_o (active-low glyph to push),
//        op_o (PUSH/POP/CLEAR), bad_o (byte is not a supported character).
module ascii_glyph_decoder
    import seg_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [6:0] glyph_o,
    output op_e        op_o,
    output logic       bad_o
);
    logic is_dig, is_hex;
    logic [3:0] nib;
    always_comb begin
        is_dig  = byte_i >= 8'h30 && byte_i <= 8'h39;
        is_hex  = is_dig || (byte_i >= 8'h41 && byte_i <= 8'h46) || (byte_i >= 8'h61 && byte_i <= 8'h66);
        // 'A'/'a' have low nibble 1, so letters map to 10..15 by adding 9
        nib     = is_dig ? byte_i[3:0] : byte_i[3:0] + 4'd9;
        op_o    = byte_i == BS ? OP_POP : (byte_i == LF || byte_i == CR) ? OP_CLEAR : OP_PUSH;
        glyph_o = is_hex ? HEX_GLYPH[nib] : byte_i == SPACE ? BLANK : DASH;
        bad_o   = !(is_hex || byte_i == SPACE || byte_i == BS || byte_i == LF || byte_i == CR);
    end
endmodule

// File: rtl/rx_display_buffer.sv
// rx_display_buffer: four-glyph scrolling window fed by received bytes, with idle blanking.
// Ports: clk/rst (sync active-high), rx_data/rx_valid (byte strobe),
//        dis_a..dis_d (oldest..newest glyph), char_count, bad_char (sticky), active.
module rx_display_buffer
    import seg_pkg::*;
#(
    parameter int IDLE_CYCLES = 100_000_000,
    parameter int CW          = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] dis_a,
    output logic [6:0] dis_b,
    output logic [6:0] dis_c,
    output logic [6:0] dis_d,
    output logic [2:0] char_count,
    output logic       bad_char,
    output logic       active
);
    localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES == 0 ? 0 : IDLE_CYCLES - 1);
    localparam bit TMO_EN = IDLE_CYCLES != 0;
    logic [6:0] win_q [4];
    logic [6:0] win_d [4];
    logic [2:0] count_q, count_d;
    logic [CW-1:0] idle_q, idle_d;
    logic bad_q, bad_d;
    state_e state_q;
    logic [6:0] glyph;
    op_e op;
    logic bad, timeout;
    ascii_glyph_decoder u_dec (
        .byte_i  (rx_data),
        .glyph_o (glyph),
        .op_o    (op),
        .bad_o   (bad)
    );
    // a strobe in the would-be timeout cycle suppresses the timeout
    assign timeout = TMO_EN && state_q == ACTIVE && !rx_valid && idle_q == LAST;
    always_comb begin
        win_d   = win_q;
        count_d = count_q;
        bad_d   = bad_q;
        idle_d  = idle_q;
        if (rx_valid) begin
            idle_d = '0;
            if (op == OP_PUSH) begin
                win_d   = '{win_q[1], win_q[2], win_q[3], glyph};
                count_d = count_q == 3'd4 ? 3'd4 : count_q + 3'd1;
                bad_d   = bad_q | bad;
            end else if (op == OP_POP && count_q != 3'd0) begin
                win_d   = '{BLANK, win_q[0], win_q[1], win_q[2]};
                count_d = count_q - 3'd1;
            end else if (op == OP_CLEAR) begin
                win_d   = '{default: BLANK};
                count_d = '0;
                bad_d   = 1'b0;
            end
        end else if (state_q == ACTIVE) begin
            idle_d = timeout ? '0 : idle_q + CW'(1);
            if (timeout) begin
                win_d   = '{default: BLANK};
                count_d = '0;
                bad_d   = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '{default: BLANK};
            count_q <= '0;
            bad_q   <= 1'b0;
            idle_q  <= '0;
            state_q <= IDLE;
        end else begin
            win_q   <= win_d;
            count_q <= count_d;
            bad_q   <= bad_d;
            idle_q  <= idle_d;
            state_q <= rx_valid ? ACTIVE : timeout ? IDLE : state_q;
        end
    end
    assign dis_a      = win_q[0];
    assign dis_b      = win_q[1];
    assign dis_c      = win_q[2];
    assign dis_d      = win_q[3];
    assign char_count = count_q;
    assign bad_char   = bad_q;
    assign active     = state_q == ACTIVE;
endmodule

// File: tb/tb_rx_display_buffer.sv
// tb_rx_display_buffer: directed scoreboard bench for rx_display_buffer with a short idle timeout.
module tb_rx_display_buffer;
    typedef struct {
        string      name;
        logic [6:0] a, b, c, d;
        logic [2:0] cnt;
        logic       bad, act;
    } exp_t;

    localparam logic [6:0] B = 7'h7F;

    logic clk = 1'b0, rst = 1'b0, rx_valid = 1'b0, obs = 1'b0, obs_seen = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [6:0] dis_a, dis_b, dis_c, dis_d;
    logic [2:0] char_count;
    logic bad_char, active;
    exp_t sb[$];
    exp_t none;
    int tests = 0, fails = 0;

    rx_display_buffer #(.IDLE_CYCLES(10), .CW(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .dis_a(dis_a), .dis_b(dis_b), .dis_c(dis_c), .dis_d(dis_d),
        .char_count(char_count), .bad_char(bad_char), .active(active)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic [6:0] a, b, c, d,
                                input logic [2:0] cnt, input logic bad, act);
        exp_t e;
        e.name = n; e.a = a; e.b = b; e.c = c; e.d = d;
        e.cnt = cnt; e.bad = bad; e.act = act;
        return e;
    endfunction

    // one clock: drive at negedge, the DUT takes it at the next posedge
    task automatic cyc(input logic r, input logic v, input logic [7:0] dat,
                       input logic o, input exp_t e);
        rst = r; rx_valid = v; rx_data = dat; obs = o;
        if (o) sb.push_back(e);
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0; obs = 1'b0;
    endtask

    task automatic send(input logic [7:0] dat, input exp_t e);
        cyc(1'b0, 1'b1, dat, 1'b1, e);
    endtask

    task automatic probe(input exp_t e);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, none);
    endtask

    // monitor: the edge after a marked stimulus cycle presents the response
    always @(posedge clk) obs_seen <= obs;

    always @(negedge clk) begin
        if (obs_seen) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL scoreboard-empty: response with no expected entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({dis_a, dis_b, dis_c, dis_d, char_count, bad_char, active} !==
                    {e.a, e.b, e.c, e.d, e.cnt, e.bad, e.act}) begin
                    fails++;
                    $display("FAIL %s: got dis=%h,%h,%h,%h cnt=%0d bad=%b act=%b expected dis=%h,%h,%h,%h cnt=%0d bad=%b act=%b",
                             e.name, dis_a, dis_b, dis_c, dis_d, char_count, bad_char, active,
                             e.a, e.b, e.c, e.d, e.cnt, e.bad, e.act);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        none = mk("none", B, B, B, B, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        cyc(1'b1, 1'b1, "7", 1'b1, mk("reset", B, B, B, B, 3'd0, 1'b0, 1'b0));
        send("1", mk("push1", B, B, B, 7'h79, 3'd1, 1'b0, 1'b1));
        send("2", mk("push2", B, B, 7'h79, 7'h24, 3'd2, 1'b0, 1'b1));
        send("3", mk("push3", B, 7'h79, 7'h24, 7'h30, 3'd3, 1'b0, 1'b1));
        send("4", mk("push4", 7'h79, 7'h24, 7'h30, 7'h19, 3'd4, 1'b0, 1'b1));
        send("a", mk("push_sat", 7'h24, 7'h30, 7'h19, 7'h08, 3'd4, 1'b0, 1'b1));
        send(8'h08, mk("bs1", B, 7'h24, 7'h30, 7'h19, 3'd3, 1'b0, 1'b1));
        send(8'h08, mk("bs2", B, B, 7'h24, 7'h30, 3'd2, 1'b0, 1'b1));
        send(8'h08, mk("bs3", B, B, B, 7'h24, 3'd1, 1'b0, 1'b1));
        send(8'h08, mk("bs4", B, B, B, B, 3'd0, 1'b0, 1'b1));
        send(8'h08, mk("bs_underflow", B, B, B, B, 3'd0, 1'b0, 1'b1));
        send("G", mk("bad_G", B, B, B, 7'h3F, 3'd1, 1'b1, 1'b1));
        send("F", mk("hex_F_sticky", B, B, 7'h3F, 7'h0E, 3'd2, 1'b1, 1'b1));
        send(8'h20, mk("space", B, 7'h3F, 7'h0E, B, 3'd3, 1'b1, 1'b1));
        send(8'h0D, mk("clear_cr", B, B, B, B, 3'd0, 1'b0, 1'b1));
        send("0", mk("push0", B, B, B, 7'h40, 3'd1, 1'b0, 1'b1));
        send("9", mk("push9", B, B, 7'h40, 7'h10, 3'd2, 1'b0, 1'b1));
        send(8'h0A, mk("clear_lf", B, B, B, B, 3'd0, 1'b0, 1'b1));
        send("5", mk("tmo_push5", B, B, B, 7'h12, 3'd1, 1'b0, 1'b1));
        idle(8);
        probe(mk("tmo_before", B, B, B, 7'h12, 3'd1, 1'b0, 1'b1));
        probe(mk("tmo_blank", B, B, B, B, 3'd0, 1'b0, 1'b0));
        probe(mk("tmo_stay_idle", B, B, B, B, 3'd0, 1'b0, 1'b0));
        send("5", mk("wake_push5", B, B, B, 7'h12, 3'd1, 1'b0, 1'b1));
        idle(8);
        probe(mk("wake_before", B, B, B, 7'h12, 3'd1, 1'b0, 1'b1));
        send("6", mk("strobe_in_tmo", B, B, 7'h12, 7'h02, 3'd2, 1'b0, 1'b1));
        idle(8);
        probe(mk("restart_before", B, B, 7'h12, 7'h02, 3'd2, 1'b0, 1'b1));
        probe(mk("restart_blank", B, B, B, B, 3'd0, 1'b0, 1'b0));
        send("z", mk("bad_z", B, B, B, 7'h3F, 3'd1, 1'b1, 1'b1));
        cyc(1'b1, 1'b1, "7", 1'b1, mk("rst_with_valid", B, B, B, B, 3'd0, 1'b0, 1'b0));
        send("8", mk("b2b_8", B, B, B, 7'h00, 3'd1, 1'b0, 1'b1));
        send("9", mk("b2b_9", B, B, 7'h00, 7'h10, 3'd2, 1'b0, 1'b1));
        idle(2);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard-drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
